// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results and control, resolves the conditional
// branch decision, and keeps saturating branch statistics.
module ex_mem_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_out,
  input  logic             ex_zero,
  input  logic [31:0]      ex_store_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch,
  input  logic [1:0]       ex_branch_type,
  input  logic [31:0]      ex_branch_target,
  output logic             mem_valid,
  output logic [31:0]      mem_alu_out,
  output logic [31:0]      mem_store_data,
  output logic [4:0]       mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,
  output logic             mem_pc_src,
  output logic [31:0]      mem_branch_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic taken;
  logic capture;
  logic count_branch;

  // blt/bge arrive as an ALU result of 1 when the condition holds, so non-zero means taken.
  always_comb begin
    taken = (ex_branch_type == 2'b00) ? ex_zero : ~ex_zero;
  end

  assign capture      = ~stall & ~flush;
  assign count_branch = capture & ex_valid & ex_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid         <= 1'b0;
      mem_alu_out       <= '0;
      mem_store_data    <= '0;
      mem_rd            <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_mem_to_reg    <= 1'b0;
      mem_pc_src        <= 1'b0;
      mem_branch_target <= '0;
    end else if (flush) begin
      mem_valid         <= 1'b0;
      mem_alu_out       <= '0;
      mem_store_data    <= '0;
      mem_rd            <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_mem_to_reg    <= 1'b0;
      mem_pc_src        <= 1'b0;
      mem_branch_target <= '0;
    end else if (!stall) begin
      // An invalid EX slot is a bubble: controls suppressed, data passes through as-is.
      mem_valid         <= ex_valid;
      mem_alu_out       <= ex_alu_out;
      mem_store_data    <= ex_store_data;
      mem_rd            <= ex_rd;
      mem_reg_write     <= ex_valid & ex_reg_write;
      mem_mem_read      <= ex_valid & ex_mem_read;
      mem_mem_write     <= ex_valid & ex_mem_write;
      mem_mem_to_reg    <= ex_valid & ex_mem_to_reg;
      mem_pc_src        <= ex_valid & ex_branch & taken;
      mem_branch_target <= ex_branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (count_branch) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (taken && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the branch statistics counters.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hold all registered state this cycle.
REQ-005 SHALL have port flush  input  1  capture a bubble instead of EX inputs.
REQ-006 SHALL have port ex_valid  input  1  EX stage holds a real instruction.
REQ-007 SHALL have port ex_alu_out  input  32  ALU result.
REQ-008 SHALL have port ex_zero  input  1  ALU zero flag (1 when result == 0).
REQ-009 SHALL have port ex_store_data  input  32  rs2 value for stores.
REQ-010 SHALL have port ex_rd  input  5  destination register.
REQ-011 SHALL have ports ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  input  1 each  control bits.
REQ-012 SHALL have port ex_branch  input  1  instruction is a conditional branch.
REQ-013 SHALL have port ex_branch_type  input  2  00 beq, 01 bne, 10 blt, 11 bge.
REQ-014 SHALL have port ex_branch_target  input  32  computed target PC.
REQ-015 SHALL have outputs mem_valid (1), mem_alu_out (32), mem_store_data (32), mem_rd (5), mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg (1 each): registered copies of the EX inputs.
REQ-016 SHALL have outputs mem_pc_src (1) and mem_branch_target (32): registered branch decision and target.
REQ-017 SHALL have outputs branch_cnt and taken_cnt, CNT_W each: saturating statistics counters.

Function
REQ-018 Capture condition: SHALL capture when stall=0 and flush=0; all outputs update exactly one clock after the EX inputs are presented.
REQ-019 Stall: stall=1 and flush=0 SHALL leave every output and both counters unchanged.
REQ-020 Flush: flush=1 SHALL capture a bubble regardless of stall (flush has priority):
  - mem_valid, all control outputs and mem_pc_src = 0
  - data outputs (mem_alu_out, mem_store_data, mem_rd, mem_branch_target) = 0
  - counters unchanged
REQ-021 Branch decision, combinational on ex_zero (blt and bge use ALU outputs of 1 when the condition is true):
  - type 00 (beq): taken = ex_zero
  - types 01, 10, 11 (bne, blt, bge): taken = ~ex_zero
REQ-022 mem_pc_src SHALL be captured as ex_valid & ex_branch & taken; mem_branch_target SHALL be captured unconditionally on capture.
REQ-023 ex_valid=0 on capture SHALL be treated as a bubble: control outputs and mem_pc_src = 0, data outputs captured as presented.
REQ-024 On capture with ex_valid=1 and ex_branch=1, branch_cnt SHALL increment by 1; taken_cnt SHALL also increment when taken=1.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 ex_branch=1 with ex_mem_read or ex_mem_write =1 is illegal; the block SHALL still register the controls as given, with no special handling.
REQ-027 All register updates SHALL be non-blocking, single clock domain, with no combinational path from input to output.

Reset
REQ-028 rst_n=0 SHALL immediately, with no clock, force every output and both counters to 0.
REQ-029 Reset asserted mid-stall or mid-flush SHALL override both; the first capture after rst_n rises SHALL follow REQ-018..REQ-025.

Verification
REQ-030 Capture: ex_valid=1, ex_alu_out=0x0000_1234, ex_rd=5, ex_reg_write=1, stall=flush=0 -> next cycle mem_alu_out=0x0000_1234, mem_rd=5, mem_reg_write=1, mem_valid=1.
REQ-031 Branch matrix, all with ex_branch=1:
  - beq, zero=1 -> mem_pc_src=1
  - bne, zero=1 -> mem_pc_src=0
  - blt, zero=0 -> mem_pc_src=1
  - bge, zero=1 -> mem_pc_src=0
  - after the four: branch_cnt=4, taken_cnt=2
REQ-032 Stall/flush priority:
  - stall=1 for 3 cycles with changing inputs -> outputs frozen
  - stall=1 and flush=1 together -> mem_valid=0, mem_pc_src=0 next cycle
REQ-033 Saturation: CNT_W=4, 20 taken branches -> branch_cnt=15, taken_cnt=15.
REQ-034 Async reset: drive rst_n low between clock edges while mem_valid=1 -> all outputs 0 before the next edge; the first capture after release is correct.
